bit_3_comparator: RTL and testbench

Registered 3-bit magnitude comparator. It compares operand A = {a2,a1,a0} against operand B = {b2,b1,b0} and produces one-hot greater/equal/less flags. The block sits on a synchronous datapath as a leaf compare unit, with a simple valid qualifier and a configurable output pipeline depth.

---
 rtl/bit_3_comparator_pkg.sv | 13 +
 rtl/bit_3_comparator_if.sv | 21 ++
 rtl/bit_3_comparator_cell.sv | 18 +
 rtl/bit_3_comparator.sv | 103 ++++++++++
 tb/tb_bit_3_comparator.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/bit_3_comparator_pkg.sv
// Shared definitions for the 3-bit magnitude comparator: operand width and
// one-hot result encoding in {gt,eq,lt} bit order.
package cmp_pkg;

    localparam int CMP_W = 3;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_GT = 3'b100;
    localparam cmp_res_t CMP_EQ = 3'b010;
    localparam cmp_res_t CMP_LT = 3'b001;

endpackage

// File: rtl/bit_3_comparator_if.sv
// Operand/flag bundle for bit_3_comparator; master drives operands, slave
// (the comparator) returns the qualified flags.
interface bit_3_comparator_if;

    logic in_valid;
    logic a2, a1, a0;
    logic b2, b1, b0;
    logic out_valid;
    logic gt, eq, lt;

    modport master (
        output in_valid, a2, a1, a0, b2, b1, b0,
        input  out_valid, gt, eq, lt
    );

    modport slave (
        input  in_valid, a2, a1, a0, b2, b1, b0,
        output out_valid, gt, eq, lt
    );

endinterface

// File: rtl/bit_3_comparator_cell.sv
// One bit of an MSB-first magnitude cascade: a decision made upstream passes
// through untouched, otherwise this bit decides or keeps the tie open.
module bit_3_comparator_cell (
    input  logic a,
    input  logic b,
    input  logic gt_in,
    input  logic eq_in,
    input  logic lt_in,
    output logic gt_out,
    output logic eq_out,
    output logic lt_out
);

    assign gt_out = gt_in | (eq_in &  a & ~b);
    assign lt_out = lt_in | (eq_in & ~a &  b);
    assign eq_out = eq_in & ~(a ^ b);

endmodule

// File: rtl/bit_3_comparator.sv
// Registered 3-bit magnitude comparator with 1 or 2 output pipeline stages.
// Define BIT3_COMPARATOR_SIGNED_EN for two's-complement operands.
module bit_3_comparator
    import cmp_pkg::*;
#(
    parameter int PIPE_STAGES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    bit_3_comparator_if.slave   cmp
);

    logic [CMP_W-1:0] a_bits;
    logic [CMP_W-1:0] b_bits;
    logic [CMP_W-1:0] cell_a;
    logic [CMP_W-1:0] cell_b;
    logic [CMP_W:0]   gt_c;
    logic [CMP_W:0]   eq_c;
    logic [CMP_W:0]   lt_c;
    cmp_res_t         res_c;

    assign a_bits = {cmp.a2, cmp.a1, cmp.a0};
    assign b_bits = {cmp.b2, cmp.b1, cmp.b0};

`ifdef BIT3_COMPARATOR_SIGNED_EN
    // A clear sign bit means the larger value, so the MSB cell sees swapped bits.
    assign cell_a = {b_bits[CMP_W-1], a_bits[CMP_W-2:0]};
    assign cell_b = {a_bits[CMP_W-1], b_bits[CMP_W-2:0]};
`else
    assign cell_a = a_bits;
    assign cell_b = b_bits;
`endif

    assign gt_c[CMP_W] = 1'b0;
    assign eq_c[CMP_W] = 1'b1;
    assign lt_c[CMP_W] = 1'b0;

    for (genvar i = CMP_W - 1; i >= 0; i--) begin : g_cell
        bit_3_comparator_cell u_cell (
            .a      (cell_a[i]),
            .b      (cell_b[i]),
            .gt_in  (gt_c[i+1]),
            .eq_in  (eq_c[i+1]),
            .lt_in  (lt_c[i+1]),
            .gt_out (gt_c[i]),
            .eq_out (eq_c[i]),
            .lt_out (lt_c[i])
        );
    end

    assign res_c = {gt_c[0], eq_c[0], lt_c[0]};

    // ---- stage p0: flags load only on valid so idle operands never reach them
    cmp_res_t res_p0;
    logic     vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            res_p0 <= '0;
        end else begin
            vld_p0 <= cmp.in_valid;
            if (cmp.in_valid) begin
                res_p0 <= res_c;
            end
        end
    end

    cmp_res_t res_out;
    logic     vld_out;

    if (PIPE_STAGES == 1) begin : g_pipe1
        assign res_out = res_p0;
        assign vld_out = vld_p0;
    end else if (PIPE_STAGES == 2) begin : g_pipe2
        // ---- stage p1
        cmp_res_t res_p1;
        logic     vld_p1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1 <= 1'b0;
                res_p1 <= '0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    res_p1 <= res_p0;
                end
            end
        end

        assign res_out = res_p1;
        assign vld_out = vld_p1;
    end else begin : g_bad_stages
        $error("bit_3_comparator: PIPE_STAGES must be 1 or 2");
    end

    assign cmp.out_valid = vld_out;
    assign cmp.gt        = res_out[2];
    assign cmp.eq        = res_out[1];
    assign cmp.lt        = res_out[0];

endmodule

// File: tb/tb_bit_3_comparator.sv
// Directed bench for bit_3_comparator: one instance per pipeline depth, shared
// clock/reset, identical operands on both. Honours BIT3_COMPARATOR_SIGNED_EN.
module tb_bit_3_comparator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bit_3_comparator_if if1 ();
    bit_3_comparator_if if2 ();

    bit_3_comparator #(.PIPE_STAGES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (if1.slave)
    );

    bit_3_comparator #(.PIPE_STAGES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (if2.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] b);
        {if1.a2, if1.a1, if1.a0} = a;
        {if1.b2, if1.b1, if1.b0} = b;
        {if2.a2, if2.a1, if2.a0} = a;
        {if2.b2, if2.b1, if2.b0} = b;
        if1.in_valid = v;
        if2.in_valid = v;
    endtask

    function automatic logic [3:0] out1();
        return {if1.out_valid, if1.gt, if1.eq, if1.lt};
    endfunction

    function automatic logic [3:0] out2();
        return {if2.out_valid, if2.gt, if2.eq, if2.lt};
    endfunction

    // Integer reference: {gt,eq,lt}
    function automatic logic [2:0] model(input logic [2:0] a, input logic [2:0] b);
        int ia, ib;
`ifdef BIT3_COMPARATOR_SIGNED_EN
        ia = a[2] ? int'(a) - 8 : int'(a);
        ib = b[2] ? int'(b) - 8 : int'(b);
`else
        ia = int'(a);
        ib = int'(b);
`endif
        if (ia > ib)       return 3'b100;
        else if (ia == ib) return 3'b010;
        else               return 3'b001;
    endfunction

    logic [2:0] va [9];
    logic [2:0] vb [9];
    logic [2:0] eu [9];
    logic [2:0] es [9];

    initial begin
        logic [2:0] ex;
        logic [2:0] ka, kb;

        // hand-computed vectors: unsigned result, signed result
        va[0] = 3'b111; vb[0] = 3'b000; eu[0] = 3'b100; es[0] = 3'b001;
        va[1] = 3'b000; vb[1] = 3'b111; eu[1] = 3'b001; es[1] = 3'b100;
        va[2] = 3'b111; vb[2] = 3'b111; eu[2] = 3'b010; es[2] = 3'b010;
        va[3] = 3'b100; vb[3] = 3'b000; eu[3] = 3'b100; es[3] = 3'b001;
        va[4] = 3'b110; vb[4] = 3'b110; eu[4] = 3'b010; es[4] = 3'b010;
        va[5] = 3'b011; vb[5] = 3'b111; eu[5] = 3'b001; es[5] = 3'b100;
        va[6] = 3'b000; vb[6] = 3'b001; eu[6] = 3'b001; es[6] = 3'b001;
        va[7] = 3'b011; vb[7] = 3'b100; eu[7] = 3'b001; es[7] = 3'b100;
        va[8] = 3'b101; vb[8] = 3'b101; eu[8] = 3'b010; es[8] = 3'b010;

        // reset held with arbitrary operands
        drive(1'b1, 3'($urandom), 3'($urandom));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_p1", out1(), 4'b0000);
        chk("reset_p2", out2(), 4'b0000);
        rst_n = 1'b1;

        drive(1'b1, va[0], vb[0]);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
`ifdef BIT3_COMPARATOR_SIGNED_EN
            ex = es[i];
`else
            ex = eu[i];
`endif
            chk($sformatf("dir%0d", i), out1(), {1'b1, ex});
            if (i < 8) drive(1'b1, va[i+1], vb[i+1]);
        end

        // all 64 pairs back-to-back
        for (int k = 0; k < 64; k++) begin
            ka = 3'(k >> 3);
            kb = 3'(k);
            drive(1'b1, ka, kb);
            @(negedge clk);
            chk($sformatf("exh_a%0d_b%0d", ka, kb), out1(), {1'b1, model(ka, kb)});
        end

        // valid gap: flags hold, idle operands (including X) ignored
        drive(1'b1, 3'b101, 3'b010);
        ex = model(3'b101, 3'b010);
        @(negedge clk);
        chk("gap_load", out1(), {1'b1, ex});
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, 3'b000, 3'b111);
            if (g == 2) begin
                if1.a2 = 1'bx; if1.b0 = 1'bz;
                if2.a2 = 1'bx; if2.b0 = 1'bz;
            end
            @(negedge clk);
            chk($sformatf("gap_hold%0d", g), out1(), {1'b0, ex});
        end

        drive(1'b0, 3'b000, 3'b000);
        repeat (3) @(negedge clk);

        // two-stage latency
        drive(1'b1, 3'b010, 3'b010);
        @(negedge clk);
        chk("p2_early", {3'b000, if2.out_valid}, 4'b0000);
        chk("p1_eq", out1(), 4'b1010);
        drive(1'b0, 3'b000, 3'b000);
        @(negedge clk);
        chk("p2_eq", out2(), 4'b1010);

        // async reset mid-pipeline
        drive(1'b1, 3'b010, 3'b010);
        @(negedge clk);
        chk("p1_before_rst", out1(), 4'b1010);
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 3'b000);
        #1;
        chk("async_clr_p1", out1(), 4'b0000);
        chk("async_clr_p2", out2(), 4'b0000);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_p2_a", out2(), 4'b0000);
        chk("post_rst_p1", out1(), 4'b0000);
        @(negedge clk);
        chk("post_rst_p2_b", out2(), 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
